// File: rtl/tx_frame_pkg.sv
// Shared types and frame-geometry helpers for the UART frame packetizer.
package tx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_e;

    function automatic int bytes_per_ch(input int data_w);
        return (data_w + 7) / 8;
    endfunction

    function automatic int frame_len(input int hdr_len, input int num_ch,
                                     input int data_w, input bit cksum);
        return hdr_len + num_ch * bytes_per_ch(data_w) + (cksum ? 1 : 0);
    endfunction

endpackage

// File: rtl/tx_frame_period_timer.sv
// Frame-period timer: saturating down-counter that powers up expired and
// restarts from PERIOD-1 whenever load_i is asserted.
module tx_frame_period_timer #(
    parameter int PERIOD = 160000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic expired_o
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(PERIOD - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_packetizer.sv
// Serialises NUM_CH channel words into header-prefixed little-endian byte frames
// paced by the UART tx_busy handshake. Define TXFRAME_CHECKSUM_EN to append a checksum.
module tx_frame_packetizer
    import tx_frame_pkg::*;
#(
    parameter int          NUM_CH   = 2,
    parameter int          DATA_W   = 10,
    parameter int          HDR_LEN  = 4,
    parameter logic [7:0]  HDR_BYTE = 8'hFF,
    parameter int          PERIOD   = 160000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     tx_busy,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    output logic                     frame_done,
    output logic                     overrun
);

`ifdef TXFRAME_CHECKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    localparam int BPC       = bytes_per_ch(DATA_W);
    localparam int PADW      = BPC * 8;
    localparam int PAY_LEN   = NUM_CH * BPC;
    localparam int FRAME_LEN = frame_len(HDR_LEN, NUM_CH, DATA_W, CKSUM_EN);
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);

    state_e                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [NUM_CH*DATA_W-1:0]  shadow_q;
    logic [7:0]                tx_data_q;
    logic [7:0]                tx_data_d;
    logic                      tx_start_q;
    logic                      frame_done_q;
    logic                      overrun_q;
    logic                      timer_expired;
    logic                      start_frame;
    logic [PAY_LEN*8-1:0]      payload;

    assign start_frame = (state_q == ST_IDLE) && enable && timer_expired;

    tx_frame_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (start_frame),
        .expired_o (timer_expired)
    );

    // Each channel is zero-extended to a whole number of bytes, channel 0 lowest.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign payload[k*PADW +: PADW] = PADW'(shadow_q[k*DATA_W +: DATA_W]);
    end

`ifdef TXFRAME_CHECKSUM_EN
    logic [7:0] cksum_q;
    logic       is_pay;

    always_comb begin
        is_pay = 1'b0;
        for (int i = 0; i < PAY_LEN; i++) begin
            if (idx_q == IDX_W'(HDR_LEN + i)) is_pay = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else if (state_q == ST_SNAP) begin
            cksum_q <= '0;
        end else if (state_q == ST_ISSUE && !tx_busy && is_pay) begin
            cksum_q <= cksum_q + tx_data_d;
        end
    end
`endif

    // Header indices fall through to HDR_BYTE; payload bytes pass through unmodified.
    always_comb begin
        tx_data_d = HDR_BYTE;
        for (int i = 0; i < PAY_LEN; i++) begin
            if (idx_q == IDX_W'(HDR_LEN + i)) tx_data_d = payload[i*8 +: 8];
        end
`ifdef TXFRAME_CHECKSUM_EN
        if (idx_q == IDX_W'(FRAME_LEN - 1)) tx_data_d = cksum_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_frame) begin
                        idx_q   <= '0;
                        state_q <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    shadow_q <= ch_data;
                    state_q  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= tx_data_d;
                        state_q    <= ST_WAIT_ACK;
                    end
                end
                // tx_busy has not risen yet in this cycle, so it is not sampled here.
                ST_WAIT_ACK: begin
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                            frame_done_q <= 1'b1;
                            overrun_q    <= timer_expired;
                            state_q      <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tx_frame_packetizer.sv
// Self-checking bench for tx_frame_packetizer with a busy-timed UART responder
// and a byte-level frame model (honours TXFRAME_CHECKSUM_EN).
module tb_tx_frame_packetizer;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 10;
    localparam int HDR_LEN = 4;
    localparam int PERIOD = 200;
    localparam int CW = NUM_CH * DATA_W;
    localparam int BPC = (DATA_W + 7) / 8;
`ifdef TXFRAME_CHECKSUM_EN
    localparam int L = HDR_LEN + NUM_CH * BPC + 1;
`else
    localparam int L = HDR_LEN + NUM_CH * BPC;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] ch_data = '0;
    logic          tx_busy = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          frame_done;
    logic          overrun;

    always #5 clk = ~clk;

    tx_frame_packetizer #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .HDR_LEN  (HDR_LEN),
        .HDR_BYTE (8'hFF),
        .PERIOD   (PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .ch_data    (ch_data),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    int n_cmp = 0;
    int n_fail = 0;

    int busy_len = 10;
    bit hold_busy = 1'b0;
    int busy_left = 0;
    bit pend = 1'b0;
    int cyc = 0;
    logic [7:0] byte_q[$];
    logic [7:0] exp_q[$];
    int gap_q[$];
    int fd_cnt = 0, ov_cnt = 0, ov_lone = 0, viol_busy = 0, viol_consec = 0;
    bit prev_start = 1'b0;
    int fd_cyc = 0;
    bit arm = 1'b0;

    // UART responder and monitor: busy is seen by the DUT for busy_len cycles
    // starting the cycle after tx_start.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy_left = 0; pend = 1'b0; prev_start = 1'b0; arm = 1'b0;
        end else begin
            if (tx_start) begin
                byte_q.push_back(tx_data);
                if (tx_busy) viol_busy++;
                if (prev_start) viol_consec++;
                if (arm) begin gap_q.push_back(cyc - fd_cyc); arm = 1'b0; end
            end
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; arm = overrun; end
            if (overrun) begin ov_cnt++; if (!frame_done) ov_lone++; end
            prev_start = tx_start;
            if (busy_left > 0) busy_left--;
            if (pend) begin busy_left = busy_len; pend = 1'b0; end
            if (tx_start) pend = 1'b1;
        end
        tx_busy = hold_busy || (busy_left > 0);
    end

    // Expected bytes of one frame: header, little-endian channel bytes, optional sum.
    task automatic model_frame(input logic [CW-1:0] d);
        longint dd, w, bt;
        int sum;
        dd = longint'(d);
        sum = 0;
        for (int h = 0; h < HDR_LEN; h++) exp_q.push_back(8'hFF);
        for (int k = 0; k < NUM_CH; k++) begin
            w = (dd >> (k * DATA_W)) % (longint'(1) << DATA_W);
            for (int b = 0; b < BPC; b++) begin
                bt = (w >> (8 * b)) % 256;
                exp_q.push_back(8'(bt));
                sum += int'(bt);
            end
        end
`ifdef TXFRAME_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_basic();
        int b0, fd0, ov0, lat, t, last, bad;
        bit got;
        ch_data = {10'h103, 10'h2A5};
        busy_len = 10;
        exp_q.delete(); model_frame(ch_data);
        b0 = byte_q.size(); fd0 = fd_cnt; ov0 = ov_cnt;
        enable = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); lat++;
            if (tx_start) break;
        end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d cycles want 3", lat); end
        t = lat; last = lat; bad = 0; got = 1'b0;
        for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk); t++;
            if (tx_start) begin
                if (t - last != busy_len + 3) bad++;
                last = t;
            end
            if (frame_done) got = 1'b1;
        end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL basic_done: got no frame_done want pulse"); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL basic_spacing: got %0d bad gaps want 0", bad); end
        n_cmp++; if (byte_q.size() - b0 != exp_q.size()) begin n_fail++; $display("FAIL basic_len: got %0d want %0d", byte_q.size() - b0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && b0 + i < byte_q.size(); i++) begin
            n_cmp++; if (byte_q[b0+i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, byte_q[b0+i], exp_q[i]); end
        end
        n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL basic_fd_count: got %0d want 1", fd_cnt - fd0); end
        n_cmp++; if (ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL basic_overrun: got %0d want 0", ov_cnt - ov0); end
    endtask

    task automatic test_random();
        int b0, fd0, ov0;
        bit got;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) ch_data = '1;
            else if (it == 1) ch_data = '0;
            else ch_data = CW'($urandom);
            busy_len = $urandom_range(1, 12);
            exp_q.delete(); model_frame(ch_data);
            b0 = byte_q.size(); fd0 = fd_cnt; ov0 = ov_cnt;
            enable = 1'b1; got = 1'b0;
            for (int i = 0; i < 1500 && !got; i++) begin
                @(negedge clk);
                if (frame_done) got = 1'b1;
            end
            enable = 1'b0;
            @(negedge clk);
            n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done: got no frame_done want pulse", it); end
            n_cmp++; if (byte_q.size() - b0 != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", it, byte_q.size() - b0, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && b0 + i < byte_q.size(); i++) begin
                n_cmp++; if (byte_q[b0+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, byte_q[b0+i], exp_q[i]); end
            end
            n_cmp++; if (fd_cnt - fd0 != 1 || ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL rand%0d_pulses: got fd=%0d ov=%0d want fd=1 ov=0", it, fd_cnt - fd0, ov_cnt - ov0); end
        end
        busy_len = 10;
    endtask

    task automatic test_snapshot();
        int b0, fd0, n;
        bit seen;
        ch_data = {10'h103, 10'h2A5};
        exp_q.delete(); model_frame(ch_data); model_frame({10'h3FF, 10'h3FF});
        b0 = byte_q.size(); fd0 = fd_cnt;
        enable = 1'b1; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        ch_data = {10'h3FF, 10'h3FF};
        n = 0;
        for (int i = 0; i < 1500 && n < 2; i++) begin
            @(negedge clk);
            if (frame_done) n++;
        end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL snap_frames: got %0d frame_done want 2", n); end
        n_cmp++; if (byte_q.size() - b0 != exp_q.size()) begin n_fail++; $display("FAIL snap_len: got %0d want %0d", byte_q.size() - b0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && b0 + i < byte_q.size(); i++) begin
            n_cmp++; if (byte_q[b0+i] !== exp_q[i]) begin n_fail++; $display("FAIL snap_byte%0d: got %h want %h", i, byte_q[b0+i], exp_q[i]); end
        end
    endtask

    task automatic test_overrun();
        int b0, fd0, ov0, ol0, g0, n;
        busy_len = 30;
        ch_data = CW'($urandom);
        b0 = byte_q.size(); fd0 = fd_cnt; ov0 = ov_cnt; ol0 = ov_lone; g0 = gap_q.size();
        enable = 1'b1; n = 0;
        for (int i = 0; i < 3000 && n < 3; i++) begin
            @(negedge clk);
            if (frame_done) n++;
        end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL ovr_frames: got %0d frame_done want 3", n); end
        n_cmp++; if (ov_cnt - ov0 != 3) begin n_fail++; $display("FAIL ovr_count: got %0d want 3", ov_cnt - ov0); end
        n_cmp++; if (ov_lone - ol0 != 0) begin n_fail++; $display("FAIL ovr_alone: got %0d want 0", ov_lone - ol0); end
        n_cmp++; if (byte_q.size() - b0 != 3 * L) begin n_fail++; $display("FAIL ovr_bytes: got %0d want %0d", byte_q.size() - b0, 3 * L); end
        n_cmp++; if (gap_q.size() - g0 != 2) begin n_fail++; $display("FAIL ovr_gaps: got %0d want 2", gap_q.size() - g0); end
        for (int i = g0; i < gap_q.size() && i < g0 + 2; i++) begin
            n_cmp++; if (gap_q[i] !== 3) begin n_fail++; $display("FAIL ovr_gap%0d: got %0d want 3", i - g0, gap_q[i]); end
        end
        busy_len = 10;
    endtask

    task automatic test_reset_mid();
        int b0, fd0, n;
        bit got;
        ch_data = CW'($urandom);
        enable = 1'b1; n = 0;
        for (int i = 0; i < 1500 && n < HDR_LEN + 3; i++) begin
            @(negedge clk);
            if (tx_start) n++;
        end
        n_cmp++; if (n !== HDR_LEN + 3) begin n_fail++; $display("FAIL rmid_reach: got %0d starts want %0d", n, HDR_LEN + 3); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({tx_data, tx_start, frame_done, overrun} !== 11'd0) begin n_fail++; $display("FAIL rmid_outputs%0d: got %h/%b/%b/%b want zero", i, tx_data, tx_start, frame_done, overrun); end
        end
        ch_data = CW'($urandom);
        exp_q.delete(); model_frame(ch_data);
        b0 = byte_q.size(); fd0 = fd_cnt;
        rst_n = 1'b1; got = 1'b0;
        for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1'b1;
        end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL rmid_done: got no frame_done want pulse"); end
        n_cmp++; if (byte_q.size() - b0 != exp_q.size()) begin n_fail++; $display("FAIL rmid_len: got %0d want %0d", byte_q.size() - b0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && b0 + i < byte_q.size(); i++) begin
            n_cmp++; if (byte_q[b0+i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_byte%0d: got %h want %h", i, byte_q[b0+i], exp_q[i]); end
        end
    endtask

    task automatic test_enable_drop();
        int b0, b1, n;
        bit got;
        ch_data = CW'($urandom);
        exp_q.delete(); model_frame(ch_data);
        b0 = byte_q.size();
        enable = 1'b1; n = 0;
        for (int i = 0; i < 800 && n < 2; i++) begin
            @(negedge clk);
            if (tx_start) n++;
        end
        enable = 1'b0; got = 1'b0;
        for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1'b1;
        end
        @(negedge clk);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL edrop_done: got no frame_done want pulse"); end
        for (int i = 0; i < exp_q.size() && b0 + i < byte_q.size(); i++) begin
            n_cmp++; if (byte_q[b0+i] !== exp_q[i]) begin n_fail++; $display("FAIL edrop_byte%0d: got %h want %h", i, byte_q[b0+i], exp_q[i]); end
        end
        repeat (400) @(negedge clk);
        n_cmp++; if (byte_q.size() - b0 != L) begin n_fail++; $display("FAIL edrop_len: got %0d want %0d", byte_q.size() - b0, L); end
        hold_busy = 1'b1;
        repeat (3) @(negedge clk);
        b1 = byte_q.size();
        enable = 1'b1;
        repeat (400) @(negedge clk);
        n_cmp++; if (byte_q.size() != b1) begin n_fail++; $display("FAIL busy_hold: got %0d starts want 0", byte_q.size() - b1); end
        n_cmp++; if (viol_busy !== 0) begin n_fail++; $display("FAIL start_while_busy: got %0d want 0", viol_busy); end
        n_cmp++; if (viol_consec !== 0) begin n_fail++; $display("FAIL start_consecutive: got %0d want 0", viol_consec); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_snapshot();
        test_overrun();
        test_reset_mid();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_packetizer.md
# tx_frame_packetizer

Parametrised successor to the fixed X/Y UART packetizer. It serialises NUM_CH channel words into framed byte streams for the UART transmitter: HDR_LEN sync bytes, then each channel split into little-endian bytes. Pacing uses the UART's tx_busy handshake instead of fixed delays. All channels are snapshotted atomically at frame start, and frames repeat on a programmable period. Sits between the game-state position registers and the UART TX core.

## Interface
- NUM_CH, 2: channels per frame (1..16)
- DATA_W, 10: bits per channel (1..32); bytes per channel BPC = ceil(DATA_W/8)
- HDR_LEN, 4: sync bytes per frame (0..8)
- HDR_BYTE, 8'hFF: sync byte value
- PERIOD, 160000: clk cycles between successive frame starts (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits new frames to start
- ch_data  in  NUM_CH*DATA_W  channel words; channel k occupies bits [k*DATA_W +: DATA_W]
- tx_busy  in  1  UART busy; rises the cycle after an accepted tx_start, falls when the byte is done
- tx_data  out  8  byte to transmit; stable from tx_start until the next tx_start
- tx_start  out  1  one-cycle request to send tx_data
- frame_done  out  1  one-cycle pulse after the final byte's tx_busy falls
- overrun  out  1  one-cycle pulse when a frame ends after its period has already expired

## Operation
- States: IDLE, SNAP, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: when enable=1 and the period timer is expired, go to SNAP, restart the timer, and clear the byte index.
- SNAP: latch all of ch_data into the shadow register. Changes to ch_data after this cycle do not affect the current frame. Go to ISSUE.
- ISSUE: issue tx_start=1 only if tx_busy=0; otherwise hold in ISSUE. Drive tx_data from the byte index, then go to WAIT_ACK.
- WAIT_ACK: ignore tx_busy for exactly 1 cycle, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0. If bytes remain, increment the index and go to ISSUE. Otherwise pulse frame_done and go to IDLE.
- Byte order:
  - Indices 0..HDR_LEN-1 are HDR_BYTE.
  - Then channel 0 byte 0 (bits 7:0), byte 1 (bits 15:8), …, then channel 1, and so on.
  - The top byte is zero-padded above DATA_W. For DATA_W=10 the high byte is {6'b0, d[9:8]}.
- Frame length L = HDR_LEN + NUM_CH*BPC, plus 1 when the checksum is enabled. The byte index is $clog2(L+1) bits wide.
- Period timer:
  - Counts down from PERIOD-1 to 0 and saturates at 0 ("expired").
  - Reset value is expired, so the first frame starts immediately.
- Overrun: if the timer is already expired when frame_done pulses, overrun pulses in the same cycle. The next frame then starts immediately (back-to-back) when enable=1.
- enable deasserted mid-frame: the current frame completes and no new frame starts.
- Payload bytes equal to HDR_BYTE are sent unmodified. The receiver resynchronises on length.

## Timing
- Reset values: tx_data=8'h00, tx_start=0, frame_done=0, overrun=0, state IDLE, index 0, shadow 0, timer expired.
- Reset asserted mid-frame aborts immediately. After release, a fresh frame starts from header byte 0; no resumption.
- Latency: IDLE→SNAP takes 1 cycle, and the first tx_start follows 2 cycles after the IDLE exit decision.
- Per byte: at least 3 cycles (ISSUE, WAIT_ACK, one WAIT_DONE cycle with tx_busy=0) plus the UART busy time.
- tx_start never asserts in consecutive cycles.
- tx_start never asserts while tx_busy=1.
- All outputs are registered.

## Configuration
- TXFRAME_CHECKSUM_EN defined: append one byte after the payload, equal to the mod-256 sum of all payload bytes (header excluded). The sum accumulates as bytes are issued.
- Not defined: no checksum byte, L = HDR_LEN + NUM_CH*BPC, and no accumulator logic.

## Structure
- Package tx_frame_pkg:
  - state enum
  - function bytes_per_ch(DATA_W)
  - function frame_len(HDR_LEN, NUM_CH, DATA_W, cksum)
- Sub-module tx_frame_period_timer:
  - PERIOD parameter, load/expired interface
  - asynchronous active-low reset, saturating down-counter
- The byte-select mux stays in the top level.

## Test plan
- Defaults, X=10'h2A5, Y=10'h103, UART model busy 10 cycles -> bytes FF FF FF FF A5 02 03 01; one frame_done pulse; no overrun.
- Same stimulus with TXFRAME_CHECKSUM_EN -> 9 bytes, last byte 8'hAB.
- ch_data changed to 0x3FF/0x3FF one cycle after SNAP -> current frame still carries A5 02 03 01; next frame carries FF 03 FF 03.
- PERIOD=20, busy 10 cycles -> overrun pulses with every frame_done; next header tx_start 3 cycles later.
- rst_n low during payload byte 2, released -> outputs zero during reset; next frame begins with full header.
- enable dropped mid-frame -> frame completes; no further tx_start; tx_busy held high -> tx_start never asserts.
